// File: rtl/ppi_pkg.sv
// Shared constants and types for the ppi_multiport parallel port block.
// Register map, CWR/STATUS bit positions and the per-port config record.
package ppi_pkg;
  localparam int MAX_PORTS = 6;

  localparam logic [2:0] ADDR_CWR    = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  localparam int CWR_DIR     = 0;
  localparam int CWR_MODE    = 1;
  localparam int CWR_IEN     = 2;
  localparam int CWR_IDX_LSB = 5;

  localparam int ST_OVR = 6;
  localparam int ST_IRQ = 7;

  typedef struct packed {
    logic ien;
    logic mode;  // 1 = strobed handshake
    logic dir;   // 1 = output
  } port_cfg_t;
endpackage

// File: rtl/ppi_multiport_if.sv
// CPU-side bus of ppi_multiport: asynchronous active-low strobes, 3-bit address, 8-bit data.
interface ppi_multiport_if;
  logic       rdb;
  logic       wrb;
  logic [2:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;

  modport master (output rdb, wrb, address, data_in, input data_out, data_oe);
  modport slave  (input rdb, wrb, address, data_in, output data_out, data_oe);
endinterface

// File: rtl/ppi_port_chan.sv
// One peripheral port: config, output register, strobed-input latch, IBF/OBF flag,
// sticky overrun and the stb/ack synchronisers.
module ppi_port_chan
  import ppi_pkg::*;
#(
  parameter int PORT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  port_cfg_t         cfg_wd,
  input  logic              wr_ev,
  input  logic [PORT_W-1:0] wdata,
  input  logic              rd_end,
  input  logic              ovr_clr,
  input  logic [PORT_W-1:0] pin,
  input  logic              stb_n,
  input  logic              ack_n,
  output logic [PORT_W-1:0] rdata,
  output logic [PORT_W-1:0] pout,
  output logic              dir,
  output logic              mode,
  output logic              ien,
  output logic              flag,
  output logic              ovr
);
  logic [1:0] s_m, s_s, s_d, s_arm;  // bit0 stb_n, bit1 ack_n
  logic       stb_fall, ack_fall;
  logic [PORT_W-1:0] pin_q, latch, out_reg;

  // First stage is never reset so arming only happens once the pin is really seen high;
  // a strobe held low through reset therefore produces neither edge.
  always_ff @(posedge clk) s_m <= {ack_n, stb_n};

  always_ff @(posedge clk) begin
    if (reset) begin
      s_s   <= '1;
      s_d   <= '1;
      s_arm <= '0;
    end else begin
      s_s   <= s_m;
      s_d   <= s_s;
      s_arm <= s_arm | (s_m & s_s);
    end
  end

  assign stb_fall = s_arm[0] & s_d[0] & ~s_s[0] & mode & ~dir;
  assign ack_fall = s_arm[1] & s_d[1] & ~s_s[1] & mode & dir;

  always_ff @(posedge clk) begin
    if (reset) begin
      {ien, mode, dir, flag, ovr} <= '0;
      pin_q   <= '0;
      latch   <= '0;
      out_reg <= '0;
    end else begin
      pin_q <= pin;
      if (ovr_clr) ovr <= 1'b0;
      if (wr_ev) out_reg <= wdata;
      // Clears come first so a same-cycle set wins.
      if (mode && !dir) begin
        if (rd_end) flag <= 1'b0;
        if (stb_fall) begin
          if (!flag || rd_end) begin
            latch <= pin;
            flag  <= 1'b1;
          end else begin
            ovr <= 1'b1;
          end
        end
      end
      if (mode && dir) begin
        if (ack_fall) flag <= 1'b0;
        if (wr_ev) begin
          flag <= 1'b1;
          if (flag && !ack_fall) ovr <= 1'b1;
        end
      end
      if (cfg_we) begin
        ien  <= cfg_wd.ien;
        mode <= cfg_wd.mode;
        dir  <= cfg_wd.dir;
        if ({cfg_wd.mode, cfg_wd.dir} != {mode, dir}) begin
          latch <= '0;
          flag  <= 1'b0;
          ovr   <= 1'b0;
        end
      end
    end
  end

  assign rdata = dir ? out_reg : (mode ? latch : pin_q);
  assign pout  = out_reg;
endmodule

// File: rtl/ppi_multiport.sv
// Multi-port PPI top: CPU strobe sync, address decode, read mux, CWR and STATUS.
// Build option PPI_IRQ_EN adds the registered irq output and STATUS[7].
module ppi_multiport
  import ppi_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  ppi_multiport_if.slave              bus,
  input  logic [NUM_PORTS*PORT_W-1:0] port_in,
  output logic [NUM_PORTS*PORT_W-1:0] port_out,
  output logic [NUM_PORTS-1:0]        port_oe,
  input  logic [NUM_PORTS-1:0]        stb_n,
  input  logic [NUM_PORTS-1:0]        ack_n
`ifdef PPI_IRQ_EN
  ,
  output logic                        irq
`endif
);
  logic [1:0] c_m, c_s, c_d, c_arm;  // bit0 rdb, bit1 wrb
  logic       rd_fall, rd_rise, wr_fall, cwr_we, st_wr;
  logic [2:0] rd_addr, cwr_idx;
  logic [MAX_PORTS-1:0]      dir_v, mode_v, ien_v, flag_v, ovr_v;
  logic [MAX_PORTS-1:0][7:0] rdata_v;
  logic       irq_bit;
  logic [7:0] rd_mux;

  always_ff @(posedge clk) c_m <= {bus.wrb, bus.rdb};

  always_ff @(posedge clk) begin
    if (reset) begin
      c_s     <= '1;
      c_d     <= '1;
      c_arm   <= '0;
      rd_addr <= '0;
      cwr_idx <= '0;
    end else begin
      c_s   <= c_m;
      c_d   <= c_s;
      c_arm <= c_arm | (c_m & c_s);
      // Side effects act on the address seen when the read started.
      if (rd_fall) rd_addr <= bus.address;
      if (cwr_we)  cwr_idx <= bus.data_in[CWR_IDX_LSB +: 3];
    end
  end

  assign rd_fall = c_arm[0] & c_d[0] & ~c_s[0];
  assign rd_rise = c_arm[0] & ~c_d[0] & c_s[0];
  assign wr_fall = c_arm[1] & c_d[1] & ~c_s[1];
  assign cwr_we  = wr_fall && bus.address == ADDR_CWR &&
                   bus.data_in[CWR_IDX_LSB +: 3] < 3'(NUM_PORTS);
  assign st_wr   = wr_fall && bus.address == ADDR_STATUS;

  for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_port
    if (gi < NUM_PORTS) begin : g_on
      logic [PORT_W-1:0] rd_w;
      ppi_port_chan #(.PORT_W(PORT_W)) u_chan (
        .clk     (clk),
        .reset   (reset),
        .cfg_we  (cwr_we && bus.data_in[CWR_IDX_LSB +: 3] == 3'(gi)),
        .cfg_wd  (port_cfg_t'(bus.data_in[CWR_IEN:CWR_DIR])),
        .wr_ev   (wr_fall && bus.address == 3'(gi)),
        .wdata   (bus.data_in[PORT_W-1:0]),
        .rd_end  (rd_rise && rd_addr == 3'(gi)),
        .ovr_clr (st_wr && bus.data_in[ST_OVR]),
        .pin     (port_in[gi*PORT_W +: PORT_W]),
        .stb_n   (stb_n[gi]),
        .ack_n   (ack_n[gi]),
        .rdata   (rd_w),
        .pout    (port_out[gi*PORT_W +: PORT_W]),
        .dir     (dir_v[gi]),
        .mode    (mode_v[gi]),
        .ien     (ien_v[gi]),
        .flag    (flag_v[gi]),
        .ovr     (ovr_v[gi])
      );
      assign rdata_v[gi] = 8'(rd_w);
      assign port_oe[gi] = dir_v[gi];
    end else begin : g_off
      assign rdata_v[gi] = '0;
      assign {dir_v[gi], mode_v[gi], ien_v[gi], flag_v[gi], ovr_v[gi]} = '0;
    end
  end

`ifdef PPI_IRQ_EN
  // Strobed input wants service when full, strobed output when empty.
  always_ff @(posedge clk) begin
    if (reset) irq_bit <= 1'b0;
    else       irq_bit <= |(ien_v & mode_v & (dir_v ^ flag_v));
  end
  assign irq = irq_bit;
`else
  assign irq_bit = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_CWR:    rd_mux = {cwr_idx, 2'b00, ien_v[cwr_idx], mode_v[cwr_idx], dir_v[cwr_idx]};
      ADDR_STATUS: rd_mux = {irq_bit, |ovr_v, flag_v};
      default:     rd_mux = rdata_v[bus.address];
    endcase
  end

  assign bus.data_oe  = ~c_s[0];
  assign bus.data_out = bus.data_oe ? rd_mux : 8'h00;
endmodule

// File: tb/tb_ppi_multiport.sv
// Directed bench for ppi_multiport: vector table for the register/port paths, hand-written
// sequences for same-cycle events, reset mid-read and (with PPI_IRQ_EN) irq timing.
module tb_ppi_multiport;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] port_in, port_out;
  logic [2:0]  port_oe, stb_n, ack_n;
  logic        irq;
  int          checks = 0;
  int          errors = 0;

  ppi_multiport_if bus ();

  ppi_multiport #(.NUM_PORTS(3), .PORT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .port_in (port_in),
    .port_out(port_out),
    .port_oe (port_oe),
    .stb_n   (stb_n),
    .ack_n   (ack_n)
`ifdef PPI_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

`ifndef PPI_IRQ_EN
  assign irq = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef enum {OP_WR, OP_RD, OP_STB, OP_ACK, OP_PIN, OP_PO, OP_OE} op_e;
  typedef struct {
    op_e        op;
    logic [2:0] a;
    logic [7:0] d;
  } vec_t;
  vec_t tv[$];

  function automatic void add(op_e op, logic [2:0] a, logic [7:0] d);
    vec_t v;
    v.op = op; v.a = a; v.d = d;
    tv.push_back(v);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  task automatic cpu_wr(logic [2:0] a, logic [7:0] d);
    bus.address = a; bus.data_in = d; bus.wrb = 1'b0;
    tick(5);
    bus.wrb = 1'b1;
    tick(5);
  endtask

  task automatic cpu_rd(logic [2:0] a, output logic [7:0] v);
    bus.address = a; bus.rdb = 1'b0;
    tick(4);
    @(negedge clk);
    v = bus.data_out;
    check("rd data_oe", 8'(bus.data_oe), 8'd1);
    @(posedge clk); #1;
    bus.rdb = 1'b1;
    tick(5);
  endtask

  task automatic strobe(int p, logic [7:0] val);
    port_in[p*8 +: 8] = val;
    tick(1);
    stb_n[p] = 1'b0;
    tick(4);
    stb_n[p] = 1'b1;
    tick(4);
  endtask

  task automatic ack(int p);
    ack_n[p] = 1'b0;
    tick(4);
    ack_n[p] = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [7:0] v;
    reset = 1'b1;
    bus.rdb = 1'b1; bus.wrb = 1'b1; bus.address = '0; bus.data_in = '0;
    port_in = '0; stb_n = '1; ack_n = '1;
    tick(3);
    @(negedge clk);
    check("reset data_oe", 8'(bus.data_oe), 8'h00);
    check("reset port_oe", 8'(port_oe), 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(3);

    // Reset state, simple out, strobed in with overrun, strobed out, unused addresses.
    add(OP_RD, 3'd7, 8'h00);  add(OP_RD, 3'd6, 8'h00);
    add(OP_WR, 3'd6, 8'h01);  add(OP_WR, 3'd0, 8'hA5);
    add(OP_PO, 3'd0, 8'hA5);  add(OP_OE, 3'd0, 8'h01);  add(OP_RD, 3'd0, 8'hA5);
    add(OP_WR, 3'd6, 8'h22);  add(OP_RD, 3'd6, 8'h22);
    add(OP_STB, 3'd1, 8'h3C); add(OP_RD, 3'd7, 8'h02);
    add(OP_STB, 3'd1, 8'h55); add(OP_RD, 3'd7, 8'h42);
    add(OP_RD, 3'd1, 8'h3C);  add(OP_RD, 3'd7, 8'h40);
    add(OP_WR, 3'd7, 8'h40);  add(OP_RD, 3'd7, 8'h00);
    add(OP_WR, 3'd6, 8'h43);  add(OP_WR, 3'd2, 8'h7E);
    add(OP_RD, 3'd7, 8'h04);  add(OP_PO, 3'd2, 8'h7E);  add(OP_OE, 3'd0, 8'h05);
    add(OP_ACK, 3'd2, 8'h00); add(OP_RD, 3'd7, 8'h00);
    add(OP_WR, 3'd2, 8'h11);  add(OP_WR, 3'd2, 8'h22);  add(OP_RD, 3'd7, 8'h44);
    add(OP_WR, 3'd7, 8'h40);  add(OP_ACK, 3'd2, 8'h00); add(OP_RD, 3'd7, 8'h00);
    add(OP_PO, 3'd2, 8'h22);
    add(OP_WR, 3'd4, 8'h99);  add(OP_RD, 3'd4, 8'h00);
    add(OP_WR, 3'd6, 8'hE1);  add(OP_RD, 3'd6, 8'h43);
    add(OP_WR, 3'd6, 8'h00);  add(OP_OE, 3'd0, 8'h04);
    add(OP_PIN, 3'd0, 8'h5A); add(OP_RD, 3'd0, 8'h5A);

    foreach (tv[i]) begin
      case (tv[i].op)
        OP_WR:  cpu_wr(tv[i].a, tv[i].d);
        OP_RD:  begin
          cpu_rd(tv[i].a, v);
          check($sformatf("vec%0d rd a%0d", i, tv[i].a), v, tv[i].d);
        end
        OP_STB: strobe(int'(tv[i].a), tv[i].d);
        OP_ACK: ack(int'(tv[i].a));
        OP_PIN: begin port_in[tv[i].a*8 +: 8] = tv[i].d; tick(2); end
        OP_PO:  begin
          @(negedge clk);
          check($sformatf("vec%0d port_out p%0d", i, tv[i].a), port_out[tv[i].a*8 +: 8], tv[i].d);
        end
        OP_OE:  begin
          @(negedge clk);
          check($sformatf("vec%0d port_oe", i), 8'(port_oe), tv[i].d);
        end
        default: ;
      endcase
    end

    // Stb edge lands in the same cycle as a port1 read-end: IBF stays set with new data.
    strobe(1, 8'h10);
    port_in[15:8] = 8'h20;
    bus.address = 3'd1; bus.rdb = 1'b0;
    tick(5);
    bus.rdb = 1'b1; stb_n[1] = 1'b0;
    tick(5);
    stb_n[1] = 1'b1;
    tick(4);
    cpu_rd(3'd7, v); check("same-cycle status", v, 8'h02);
    cpu_rd(3'd1, v); check("same-cycle latch", v, 8'h20);
    cpu_rd(3'd7, v); check("same-cycle cleared", v, 8'h00);

    // Reset with rdb low: the later rdb rise must not clear port0's IBF.
    bus.address = 3'd0; bus.rdb = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("mid-reset port_oe", 8'(port_oe), 8'h00);
    cpu_wr(3'd6, 8'h02);
    strobe(0, 8'h77);
    bus.rdb = 1'b1;
    tick(6);
    cpu_rd(3'd7, v); check("abort status", v, 8'h01);
    cpu_rd(3'd0, v); check("abort latch", v, 8'h77);
    cpu_rd(3'd7, v); check("abort cleared", v, 8'h00);

    // Interrupt on strobed input with ien set.
    cpu_wr(3'd6, 8'h26);
    port_in[15:8] = 8'h44;
    tick(1);
    stb_n[1] = 1'b0;
    tick(3);
    @(negedge clk);
    check("irq before", 8'(irq), 8'h00);
    @(posedge clk);
    @(negedge clk);
`ifdef PPI_IRQ_EN
    check("irq after ibf", 8'(irq), 8'h01);
`else
    check("irq absent", 8'(irq), 8'h00);
`endif
    @(posedge clk); #1;
    stb_n[1] = 1'b1;
    tick(4);
    cpu_rd(3'd7, v);
`ifdef PPI_IRQ_EN
    check("status irq", v, 8'h82);
`else
    check("status no irq", v, 8'h02);
`endif
    cpu_rd(3'd1, v); check("irq port1 data", v, 8'h44);
    @(negedge clk);
    check("irq after read", 8'(irq), 8'h00);
    cpu_rd(3'd7, v); check("final status", v, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
